pwm_gen: RTL and testbench

- Gate-drive PWM generator: the consumer of the off-time/period values produced by the PWM control-law block.
- Produces a fixed on-time followed by a variable off-time each period.
- Each period it issues a pwm_en request to the control-law block and latches that block's off_div/total_time results into shadow registers at the next period boundary, provided pwm_rdy is high at that point.
- Sits between the control loop and the power-stage gate driver.

---
 rtl/pwm_gen.sv | 141 ++++++++++++++
 tb/tb_pwm_gen.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - fixed on-time / variable off-time gate PWM with shadowed control-law inputs
module pwm_gen #(
  parameter int ON_TIME       = 40,
  parameter int CNT_WIDTH     = 18,
  parameter int START_OFF_DIV = 100,
  parameter int MIN_OFF_DIV   = 1,
  parameter int TOTAL_TIME    = 400
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 run,
  input  logic [CNT_WIDTH-1:0] off_div,
  input  logic [CNT_WIDTH-1:0] total_time,
  input  logic                 pwm_rdy,
  output logic                 pwm_en,
  output logic                 gate,
  output logic                 cyc_start,
  output logic                 stale
);

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  localparam logic [CNT_WIDTH:0]   ON_W    = (CNT_WIDTH+1)'(ON_TIME);
  localparam logic [CNT_WIDTH:0]   MIN_W   = (CNT_WIDTH+1)'(MIN_OFF_DIV);
  localparam logic [CNT_WIDTH-1:0] ON_LAST = CNT_WIDTH'(ON_TIME - 1);
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

  // One bit of headroom so ON_TIME + off never wraps for any 18-bit request.
  function automatic logic [CNT_WIDTH-1:0] clamp_off(input logic [CNT_WIDTH-1:0] od,
                                                      input logic [CNT_WIDTH-1:0] tt);
    logic [CNT_WIDTH:0] o;
    logic [CNT_WIDTH:0] t;
    t = {1'b0, tt};
    o = {1'b0, od};
    if (od[CNT_WIDTH-1] || (o < MIN_W)) o = MIN_W;
    if (t < ON_W + MIN_W) o = MIN_W;
    else if (ON_W + o > t) o = t - ON_W;
    return o[CNT_WIDTH-1:0];
  endfunction

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] off_sh_q, off_sh_d;
  logic [CNT_WIDTH-1:0] tt_sh_q, tt_sh_d;
  logic                 gate_q, gate_d;
  logic                 pwm_en_q, pwm_en_d;
  logic                 cyc_start_q, cyc_start_d;
  logic                 stale_q, stale_d;
  logic [CNT_WIDTH-1:0] off_eff;
  logic                 start;
  logic                 latch;

  assign off_eff = clamp_off(off_sh_q, tt_sh_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    off_sh_d    = off_sh_q;
    tt_sh_d     = tt_sh_q;
    gate_d      = 1'b0;
    pwm_en_d    = 1'b0;
    cyc_start_d = 1'b0;
    stale_d     = stale_q;
    start       = 1'b0;
    latch       = 1'b0;
    case (state_q)
      IDLE: begin
        stale_d = 1'b0;
        if (run && pwm_rdy) begin
          start = 1'b1;
          latch = 1'b1;
        end
      end
      ON: begin
        if (cnt_q == ON_LAST) begin
          state_d  = OFF;
          cnt_d    = '0;
          pwm_en_d = pwm_rdy;
        end else begin
          cnt_d  = cnt_q + ONE;
          gate_d = 1'b1;
        end
      end
      OFF: begin
        if (cnt_q == off_eff - ONE) begin
          if (!run) begin
            state_d = IDLE;
            cnt_d   = '0;
            stale_d = 1'b0;
          end else begin
            // A busy control law keeps the old shadows and flags the period.
            start   = 1'b1;
            latch   = pwm_rdy;
            stale_d = !pwm_rdy;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d     = ON;
      cnt_d       = '0;
      gate_d      = 1'b1;
      cyc_start_d = 1'b1;
    end
    if (latch) begin
      off_sh_d = off_div;
      tt_sh_d  = total_time;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      off_sh_q    <= CNT_WIDTH'(START_OFF_DIV);
      tt_sh_q     <= CNT_WIDTH'(TOTAL_TIME);
      gate_q      <= 1'b0;
      pwm_en_q    <= 1'b0;
      cyc_start_q <= 1'b0;
      stale_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      off_sh_q    <= off_sh_d;
      tt_sh_q     <= tt_sh_d;
      gate_q      <= gate_d;
      pwm_en_q    <= pwm_en_d;
      cyc_start_q <= cyc_start_d;
      stale_q     <= stale_d;
    end
  end

  assign gate      = gate_q;
  assign pwm_en    = pwm_en_q;
  assign cyc_start = cyc_start_q;
  assign stale     = stale_q;

endmodule

// File: tb/tb_pwm_gen.sv
// tb/tb_pwm_gen.sv - self-checking bench for pwm_gen: period-level model plus directed period measurements
module tb_pwm_gen;

  localparam int ON = 40;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        run = 1'b0;
  logic [17:0] off_div = 18'd100;
  logic [17:0] total_time = 18'd400;
  logic        pwm_rdy = 1'b1;
  logic        pwm_en, gate, cyc_start, stale;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  pwm_gen dut (
    .clk(clk), .n_rst(n_rst), .run(run), .off_div(off_div), .total_time(total_time),
    .pwm_rdy(pwm_rdy), .pwm_en(pwm_en), .gate(gate), .cyc_start(cyc_start), .stale(stale)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Off-time the period should use, straight from the clamp rules.
  function automatic int off_len(input logic [17:0] od, input logic [17:0] tt);
    int o;
    int t;
    t = int'(tt);
    o = (od[17] || od == 0) ? 1 : int'(od);
    if (t < ON + 1) return 1;
    if (ON + o > t) o = t - ON;
    return o;
  endfunction

  // Model: position within the current period and that period's off length.
  bit m_act = 0;
  int m_k = 0;
  int m_off = 100;
  bit m_stale = 0;
  bit m_pen = 0;
  int k_old;
  bit begin_period;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_act = 0; m_k = 0; m_stale = 0; m_pen = 0; m_off = off_len(18'd100, 18'd400);
    end else begin
      k_old = m_k;
      begin_period = 0;
      m_pen = m_act && (k_old == ON - 1) && pwm_rdy;
      if (!m_act) begin
        if (run && pwm_rdy) begin
          begin_period = 1; m_off = off_len(off_div, total_time); m_stale = 0;
        end
      end else if (k_old == ON + m_off - 1) begin
        if (!run) begin
          m_act = 0; m_k = 0; m_stale = 0;
        end else begin
          begin_period = 1;
          if (pwm_rdy) begin
            m_off = off_len(off_div, total_time); m_stale = 0;
          end else m_stale = 1;
        end
      end else m_k = k_old + 1;
      if (begin_period) begin
        m_act = 1; m_k = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("gate", gate, m_act && (m_k < ON));
      check("cyc_start", cyc_start, m_act && (m_k == 0));
      check("pwm_en", pwm_en, m_pen);
      check("stale", stale, m_stale);
    end
  end

  task automatic wait_start(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!cyc_start && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!cyc_start) check({nm, "_start_timeout"}, 0, 1);
  endtask

  task automatic run_case(input string nm, input int hi_e, input int lo_e, input int pen_e,
                          input int st_e);
    int hi, lo, pen_at, n;
    logic st;
    hi = 0; lo = 0; pen_at = -1; n = 0;
    wait_start(nm);
    st = stale;
    do begin
      if (gate) hi++; else lo++;
      if (pwm_en) pen_at = n;
      n++;
      @(negedge clk);
    end while (!cyc_start && n < 2000);
    check({nm, "_on"}, hi, hi_e);
    check({nm, "_off"}, lo, lo_e);
    check({nm, "_pwm_en_pos"}, pen_at, pen_e);
    check({nm, "_stale"}, st, st_e);
  endtask

  initial begin
    int hi, cs;
    @(negedge clk);
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_gate", gate, 0);
    check("rst_pwm_en", pwm_en, 0);
    check("rst_cyc_start", cyc_start, 0);
    check("rst_stale", stale, 0);
    n_rst = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_gate", gate, 0);
    check("idle_cyc_start", cyc_start, 0);

    run = 1'b1;
    run_case("steady1", 40, 100, 40, 0);
    run_case("steady2", 40, 100, 40, 0);

    off_div = 18'd500;
    run_case("clamp_tt", 40, 360, 40, 0);
    off_div = 18'd0;
    run_case("clamp_zero", 40, 1, 40, 0);
    off_div = 18'h20005;
    run_case("clamp_msb", 40, 1, 40, 0);
    off_div = 18'd100; total_time = 18'd30;
    run_case("clamp_short_tt", 40, 1, 40, 0);
    total_time = 18'd400;
    run_case("restore", 40, 100, 40, 0);

    off_div = 18'd200; pwm_rdy = 1'b0;
    run_case("busy", 40, 100, -1, 1);
    pwm_rdy = 1'b1;
    run_case("busy_after", 40, 200, 40, 0);

    wait_start("run_drop");
    hi = 0; cs = 0;
    for (int i = 0; i < 600; i++) begin
      if (i == 10) run = 1'b0;
      if (gate) hi++;
      if (i > 0 && cyc_start) cs++;
      @(negedge clk);
    end
    check("run_drop_on", hi, 40);
    check("run_drop_restarts", cs, 0);
    check("run_drop_gate", gate, 0);

    off_div = 18'd100; total_time = 18'd400; run = 1'b1;
    wait_start("rst_mid");
    repeat (20) @(negedge clk);
    check("rst_mid_gate_before", gate, 1);
    #2 n_rst = 1'b0;
    #1 check("rst_mid_gate", gate, 0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    run_case("after_reset", 40, 100, 40, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
